// File: rtl/rcs_flag_stage.sv
// rcs_flag_stage: registered difference/flag stage with 2-entry skid buffer behind the ripple-carry subtractor.
// Optional feature macro: STICKY_OVF_EN adds sticky_clr input and sticky_ovf output.
module rcs_flag_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef STICKY_OVF_EN
    input  logic             sticky_clr,
    output logic             sticky_ovf,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_diff,
    input  logic             in_carry,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_borrow,
    output logic             out_ovf,
    output logic             out_lt_s
);
    localparam int W = WIDTH + 5;
    logic [W-1:0] in_word, main_q, skid_q;
    logic         main_valid, skid_valid, accept, xfer, f_neg, f_ovf;
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid & ~skid_valid;
    assign xfer      = main_valid & out_ready;
    assign {out_diff, out_zero, out_neg, out_borrow, out_ovf, out_lt_s} = main_q;
    // flags derived from the incoming word and stored alongside the difference
    always_comb begin
        f_neg   = in_diff[WIDTH-1];
        f_ovf   = (in_a_msb ^ in_b_msb) & (in_diff[WIDTH-1] ^ in_a_msb);
        in_word = {in_diff, ~|in_diff, f_neg, ~in_carry, f_ovf, f_neg ^ f_ovf};
    end
    // main/skid entries: skid drains into main first, so ordering stays FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (xfer && skid_valid) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
        end else if (accept && (!main_valid || xfer)) begin
            main_q     <= in_word;
            main_valid <= 1'b1;
        end else if (accept) begin
            skid_q     <= in_word;
            skid_valid <= 1'b1;
        end else if (xfer) begin
            main_valid <= 1'b0;
        end
    end
`ifdef STICKY_OVF_EN
    // sticky overflow: set by an overflowing transfer-out, which wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_ovf <= 1'b0;
        else        sticky_ovf <= (xfer & out_ovf) | (sticky_ovf & ~sticky_clr);
    end
`endif
endmodule

// File: tb/tb_rcs_flag_stage.sv
// tb_rcs_flag_stage: randomized and directed checks of rcs_flag_stage against an a/b-level reference model.
module tb_rcs_flag_stage;
    typedef struct packed {
        logic [31:0] d;
        logic        z, n, b, o, l;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, in_carry = 1'b0, in_a_msb = 1'b0, in_b_msb = 1'b0;
    logic [31:0] in_diff = '0, out_diff, cur_a = '0, cur_b = '0;
    logic        out_valid, out_ready = 1'b0, out_zero, out_neg, out_borrow, out_ovf, out_lt_s;
    logic        sticky_clr = 1'b0, sticky_ovf, sticky_exp = 1'b0, last_acc = 1'b0, acc, xf;
    int          checks = 0, errors = 0;
    exp_t        q[$];
    exp_t        h;

    rcs_flag_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef STICKY_OVF_EN
        .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_diff(in_diff), .in_carry(in_carry),
        .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .out_valid(out_valid), .out_ready(out_ready), .out_diff(out_diff), .out_zero(out_zero),
        .out_neg(out_neg), .out_borrow(out_borrow), .out_ovf(out_ovf), .out_lt_s(out_lt_s)
    );
`ifndef STICKY_OVF_EN
    assign sticky_ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    // expected flags straight from the arithmetic meaning of a - b
    function automatic exp_t ref_of(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sd;
        sd  = longint'($signed(a)) - longint'($signed(b));
        e.d = a - b;
        e.z = (a == b);
        e.n = e.d[31];
        e.b = (a < b);
        e.o = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        e.l = ($signed(a) < $signed(b));
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] b);
        cur_a    = a;
        cur_b    = b;
        in_diff  = a - b;
        in_carry = (a >= b);
        in_a_msb = a[31];
        in_b_msb = b[31];
        in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [31:0] d, input logic [4:0] f);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_diff"}, out_diff, d);
        chk({name, "_flags"}, {out_zero, out_neg, out_borrow, out_ovf, out_lt_s}, f);
    endtask

    // reference model: the stage is a FIFO of depth two whose head drives the outputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            last_acc   = 1'b0;
            sticky_exp = 1'b0;
        end else begin
            acc = in_valid && (q.size() < 2);
            xf  = (q.size() > 0) && out_ready;
            if (xf && q[0].o) sticky_exp = 1'b1;
            else if (sticky_clr) sticky_exp = 1'b0;
            if (xf) void'(q.pop_front());
            if (acc) q.push_back(ref_of(cur_a, cur_b));
            last_acc = acc;
        end
    end

    // per-cycle comparison of the DUT against the model head
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() < 2);
            if (q.size() > 0) begin
                h = q[0];
                chk("out_diff", out_diff, h.d);
                chk("out_flags", {out_zero, out_neg, out_borrow, out_ovf, out_lt_s}, {h.z, h.n, h.b, h.o, h.l});
            end
`ifdef STICKY_OVF_EN
            chk("sticky_ovf", sticky_ovf, sticky_exp);
`endif
        end
    end

    initial begin
        logic [31:0] edge_v[4];
        int          sel;
        edge_v = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_diff", out_diff, 0);
        chk("rst_flags", {out_zero, out_neg, out_borrow, out_ovf, out_lt_s, sticky_ovf}, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        put(32'd5, 32'd0);
        tick();
        lit("w5", 32'd5, 5'b00000);
        put(32'd3, 32'd4);
        tick();
        lit("w_m1", 32'hFFFF_FFFF, 5'b01101);
        put(32'd5, 32'd5);
        tick();
        lit("w_zero", 32'd0, 5'b10000);
        put(32'h8000_0000, 32'd1);
        tick();
        lit("w_ovf", 32'h7FFF_FFFF, 5'b00011);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        put(32'd1, 32'd0);
        tick();
        put(32'd2, 32'd0);
        tick();
        put(32'd3, 32'd0);
        tick();
        chk("stall_in_ready", in_ready, 0);
        chk("stall_head", out_diff, 1);
        tick();
        chk("stall_hold_ready", in_ready, 0);
        chk("stall_hold_head", out_diff, 1);
        out_ready = 1'b1;
        tick();
        chk("drain_second", out_diff, 2);
        chk("drain_ready", in_ready, 1);
        tick();
        chk("drain_third", out_diff, 3);
        in_valid = 1'b0;
        tick();
        chk("drain_empty", out_valid, 0);
`ifdef STICKY_OVF_EN
        chk("sticky_persist", sticky_ovf, 1);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("sticky_cleared", sticky_ovf, 0);
        put(32'h8000_0000, 32'd1);
        tick();
        in_valid   = 1'b0;
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("sticky_set_wins", sticky_ovf, 1);
`endif
        out_ready = 1'b0;
        put(32'd9, 32'd0);
        tick();
        put(32'd10, 32'd0);
        tick();
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_diff", {out_diff, out_zero, out_neg, out_borrow, out_ovf, out_lt_s, sticky_ovf}, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        put(32'h1234, 32'h34);
        tick();
        lit("post_rst", 32'h1200, 5'b00000);
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 3000; i++) begin
            out_ready = (i % 200 < 60) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            if (!(in_valid && !last_acc)) begin
                if ($urandom % 4 != 0) begin
                    sel = $urandom % 4;
                    if (sel == 0) put($urandom, $urandom);
                    else if (sel == 1) begin
                        cur_a = $urandom;
                        put(cur_a, cur_a);
                    end else if (sel == 2) put(edge_v[$urandom % 4], edge_v[$urandom % 4]);
                    else put($urandom % 16, $urandom % 16);
                end else in_valid = 1'b0;
            end
            sticky_clr = ($urandom % 8 == 0);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
